// File: rtl/bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// bus_arbiter_if
//
// Bundles the request/grant handshake and the shared-bus transaction strobes
// seen by the round-robin bus arbiter.
//
// Signals:
//   request             one bit per master, level-sensitive
//   grant               one-hot (or zero) grant, driven by the arbiter
//   begin_transactionIN shared-bus begin strobe
//   end_transactionIN   shared-bus end strobe (master or slave)
//   errorIN             shared-bus error from a slave
//   end_transactionOUT  one-cycle pulse driven by the arbiter on a watchdog abort
//   errorOUT            one-cycle pulse driven by the arbiter on a watchdog abort
//   bus_active          high while a master owns the bus
//   current_master      index of the granted master
//
// Modports:
//   slave  - the arbiter side (serves requests, drives grant and abort strobes)
//   master - the requester / bus side
// -----------------------------------------------------------------------------
interface bus_arbiter_if #(
    parameter int NR_OF_MASTERS = 4
);
    localparam int MASTER_W = $clog2(NR_OF_MASTERS);

    logic [NR_OF_MASTERS-1:0] request;
    logic [NR_OF_MASTERS-1:0] grant;
    logic                     begin_transactionIN;
    logic                     end_transactionIN;
    logic                     errorIN;
    logic                     end_transactionOUT;
    logic                     errorOUT;
    logic                     bus_active;
    logic [MASTER_W-1:0]      current_master;

    modport slave (
        input  request,
        input  begin_transactionIN,
        input  end_transactionIN,
        input  errorIN,
        output grant,
        output end_transactionOUT,
        output errorOUT,
        output bus_active,
        output current_master
    );

    modport master (
        output request,
        output begin_transactionIN,
        output end_transactionIN,
        output errorIN,
        input  grant,
        input  end_transactionOUT,
        input  errorOUT,
        input  bus_active,
        input  current_master
    );
endinterface

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Round-robin arbiter for a shared bus. Grants the bus to one requesting master,
// follows the transaction on the shared begin/end/error strobes and holds the
// grant until the transaction ends. A watchdog gives up on a master that never
// begins (silent release) and aborts a transaction that never ends (one-cycle
// errorOUT + end_transactionOUT pulse in the last ACTIVE cycle).
//
// Parameters:
//   NR_OF_MASTERS        number of requesters (2..16)
//   BEGIN_TIMEOUT        grant cycles allowed before a begin must be seen
//   TRANSACTION_TIMEOUT  ACTIVE cycles allowed, the abort cycle included
//
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high reset
//   bus    bus_arbiter_if.slave: request/grant handshake, bus strobes, status
//
// All outputs are registered; there is no input-to-output combinational path.
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int NR_OF_MASTERS       = 4,
    parameter int BEGIN_TIMEOUT       = 16,
    parameter int TRANSACTION_TIMEOUT = 256
) (
    input  logic         clock,
    input  logic         reset,
    bus_arbiter_if.slave bus
);
    localparam int MASTER_W = $clog2(NR_OF_MASTERS);
    localparam int BEGIN_W  = (BEGIN_TIMEOUT > 1) ? $clog2(BEGIN_TIMEOUT) : 1;
    localparam int XFER_W   = (TRANSACTION_TIMEOUT > 1) ? $clog2(TRANSACTION_TIMEOUT) : 1;

    // Last grant cycle when no begin shows up.
    localparam logic [BEGIN_W-1:0] BEGIN_LAST = BEGIN_W'(BEGIN_TIMEOUT - 1);
    // The abort is decided one cycle early so the registered pulse lands in
    // the final (TRANSACTION_TIMEOUT-th) ACTIVE cycle while grant is still high.
    // A bus end seen on that deciding edge wins and no pulse is produced.
    localparam logic [XFER_W-1:0]  XFER_ARM   = XFER_W'(TRANSACTION_TIMEOUT - 2);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        ACTIVE,
        RELEASE
    } state_t;

    state_t              state;
    logic [MASTER_W-1:0] last_master;
    logic [BEGIN_W-1:0]  begin_cnt;
    logic [XFER_W-1:0]   xfer_cnt;

    // Round-robin pick: first requester at or above last_master+1, wrapping.
    logic                any_request;
    logic [MASTER_W-1:0] winner;
    logic [MASTER_W-1:0] probe;

    always_comb begin
        // NOTE: every variable gets a default before the loop so no path
        // leaves it unassigned, which would otherwise infer a latch.
        any_request = 1'b0;
        winner      = '0;
        probe       = '0;
        // Scan from the farthest candidate to the nearest; the nearest
        // requester is written last and therefore wins.
        for (int i = NR_OF_MASTERS; i >= 1; i--) begin
            probe = MASTER_W'((int'(last_master) + i) % NR_OF_MASTERS);
            if (bus.request[probe]) begin
                winner      = probe;
                any_request = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: all state and outputs here use non-blocking assignments so
        // every register samples the pre-edge values of its neighbours.
        if (reset) begin
            state                  <= IDLE;
            bus.grant              <= '0;
            bus.bus_active         <= 1'b0;
            bus.errorOUT           <= 1'b0;
            bus.end_transactionOUT <= 1'b0;
            bus.current_master     <= '0;
            last_master            <= MASTER_W'(NR_OF_MASTERS - 1);
            begin_cnt              <= '0;
            xfer_cnt               <= '0;
        end else begin
            // Abort strobes are single-cycle unless set again below.
            bus.errorOUT           <= 1'b0;
            bus.end_transactionOUT <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (any_request) begin
                        state              <= GRANT;
                        bus.grant          <= NR_OF_MASTERS'(1) << winner;
                        bus.bus_active     <= 1'b1;
                        bus.current_master <= winner;
                        last_master        <= winner;
                        begin_cnt          <= '0;
                    end
                end

                GRANT: begin
                    if (bus.begin_transactionIN) begin
                        // Begin wins even on the timeout cycle.
                        state     <= ACTIVE;
                        begin_cnt <= '0;
                        xfer_cnt  <= '0;
                    end else if (begin_cnt == BEGIN_LAST) begin
                        // Nothing was opened on the bus, so release silently.
                        state          <= RELEASE;
                        bus.grant      <= '0;
                        bus.bus_active <= 1'b0;
                    end else begin
                        begin_cnt <= begin_cnt + 1'b1;
                    end
                end

                ACTIVE: begin
                    // errorOUT high means this is the abort cycle: leave now.
                    if (bus.end_transactionIN || bus.errorIN || bus.errorOUT) begin
                        state          <= RELEASE;
                        bus.grant      <= '0;
                        bus.bus_active <= 1'b0;
                    end else begin
                        // Never exceeds TRANSACTION_TIMEOUT-1: the cycle after
                        // reaching it always leaves ACTIVE.
                        xfer_cnt <= xfer_cnt + 1'b1;
                        if (xfer_cnt == XFER_ARM) begin
                            bus.errorOUT           <= 1'b1;
                            bus.end_transactionOUT <= 1'b1;
                        end
                    end
                end

                RELEASE: begin
                    // One turnaround cycle; requests are not looked at here.
                    state     <= IDLE;
                    begin_cnt <= '0;
                    xfer_cnt  <= '0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Self-checking bench for bus_arbiter (4 masters, BEGIN_TIMEOUT=16,
// TRANSACTION_TIMEOUT=256). Inputs are driven 1 time unit after each rising
// edge and outputs are sampled at the same point, so an input driven in cycle
// n is seen by the edge that opens cycle n+1.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;
    localparam int NR = 4;
    localparam int BT = 16;
    localparam int TT = 256;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    bus_arbiter_if #(.NR_OF_MASTERS(NR)) bus ();

    bus_arbiter #(
        .NR_OF_MASTERS      (NR),
        .BEGIN_TIMEOUT      (BT),
        .TRANSACTION_TIMEOUT(TT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.request             = '0;
        bus.begin_transactionIN = 1'b0;
        bus.end_transactionIN   = 1'b0;
        bus.errorIN             = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic int onehot_idx(input logic [NR-1:0] g);
        onehot_idx = -1;
        for (int i = 0; i < NR; i++) if (g[i]) onehot_idx = i;
    endfunction

    // -------------------------------------------------------------------------
    // Reference model: who owns the bus and for how many cycles, stepped once
    // per clock edge from the same inputs the DUT samples.
    // -------------------------------------------------------------------------
    int m_owner;      // granted master, -1 when nobody holds the bus
    bit m_begun;      // transaction opened on the bus
    int m_held;       // cycles spent so far in the current phase (current one included)
    bit m_turnaround; // current cycle is the post-release turnaround
    bit m_abort;      // current cycle carries the abort pulse
    int m_last;
    int m_cur;

    function automatic void model_reset();
        m_owner      = -1;
        m_begun      = 1'b0;
        m_held       = 0;
        m_turnaround = 1'b0;
        m_abort      = 1'b0;
        m_last       = NR - 1;
        m_cur        = 0;
    endfunction

    function automatic void model_release();
        m_owner      = -1;
        m_turnaround = 1'b1;
        m_abort      = 1'b0;
    endfunction

    function automatic void model_edge(input logic rst, input logic [NR-1:0] req,
                                       input logic beg, input logic en, input logic er);
        if (rst) begin
            model_reset();
        end else if (m_turnaround) begin
            m_turnaround = 1'b0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= NR; k++) begin
                if (m_owner < 0 && req[(m_last + k) % NR]) m_owner = (m_last + k) % NR;
            end
            if (m_owner >= 0) begin
                m_last  = m_owner;
                m_cur   = m_owner;
                m_begun = 1'b0;
                m_held  = 1;
            end
        end else if (!m_begun) begin
            if (beg) begin
                m_begun = 1'b1;
                m_held  = 1;
            end else if (m_held == BT) begin
                model_release();
            end else begin
                m_held++;
            end
        end else begin
            if (en || er || m_abort) begin
                model_release();
            end else begin
                m_held++;
                if (m_held == TT) m_abort = 1'b1;
            end
        end
    endfunction

    function automatic logic [8:0] model_outputs();
        logic [NR-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return {g, (m_owner >= 0), m_abort, m_abort, 2'(m_cur)};
    endfunction

    // -------------------------------------------------------------------------
    // Vector table: inputs driven for one cycle, outputs expected after the edge.
    // -------------------------------------------------------------------------
    typedef struct {
        logic          rst;
        logic [NR-1:0] req;
        logic          beg;
        logic          en;
        logic          er;
        logic [NR-1:0] grant;
        logic          active;
        logic [1:0]    cur;
    } vec_t;

    vec_t vecs[17];

    // Working variables for the hand-written sequences.
    int order[$];
    int gaps[$];
    int held;
    int gap;
    int run;
    bit err_seen;
    int act_n;
    int pulse_n;
    int pulse_cycle;
    bit pair_ok;

    task automatic xfer_timeout_run(input int end_at);
        do_reset();
        bus.request = 4'b0001;
        tick();
        check("xto_first_grant", bus.grant, 4'b0001);
        bus.begin_transactionIN = 1'b1;
        bus.request             = '0;
        tick();
        bus.begin_transactionIN = 1'b0;
        act_n       = 0;
        pulse_n     = 0;
        pulse_cycle = 0;
        pair_ok     = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (bus.grant == '0) break;
            act_n++;
            if (bus.errorOUT) begin
                pulse_n++;
                pulse_cycle = act_n;
            end
            if (bus.errorOUT !== bus.end_transactionOUT) pair_ok = 1'b0;
            bus.end_transactionIN = (act_n == end_at);
            tick();
        end
        bus.end_transactionIN = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        do_reset();

        // Reset state.
        check("reset_grant", bus.grant, '0);
        check("reset_active", bus.bus_active, 1'b0);
        check("reset_error", bus.errorOUT, 1'b0);
        check("reset_end_out", bus.end_transactionOUT, 1'b0);
        check("reset_current", bus.current_master, '0);

        // ---- table-driven sequence ----
        //            rst req     beg en  er   grant   act cur
        vecs[0]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
        vecs[1]  = '{1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2}; // 1-cycle grant latency
        vecs[2]  = '{1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2};
        vecs[3]  = '{1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2}; // begin -> ACTIVE
        vecs[4]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2}; // request dropped, grant held
        vecs[5]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2};
        vecs[6]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2}; // end -> RELEASE
        vecs[7]  = '{1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2}; // RELEASE -> IDLE
        vecs[8]  = '{1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0}; // search wraps 3 -> 0
        vecs[9]  = '{1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0}; // errorIN ignored in GRANT
        vecs[10] = '{1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0};
        vecs[11] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0}; // slave error -> RELEASE
        vecs[12] = '{1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
        vecs[13] = '{1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1}; // next after master 0
        vecs[14] = '{1'b0, 4'b1111, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1}; // end ignored in GRANT
        vecs[15] = '{1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0}; // reset while granted
        vecs[16] = '{1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0}; // master 0 first after reset

        for (int i = 0; i < 17; i++) begin
            reset                   = vecs[i].rst;
            bus.request             = vecs[i].req;
            bus.begin_transactionIN = vecs[i].beg;
            bus.end_transactionIN   = vecs[i].en;
            bus.errorIN             = vecs[i].er;
            tick();
            check($sformatf("vec%0d_grant", i), bus.grant, vecs[i].grant);
            check($sformatf("vec%0d_active", i), bus.bus_active, vecs[i].active);
            check($sformatf("vec%0d_current", i), bus.current_master, vecs[i].cur);
            check($sformatf("vec%0d_error", i), {bus.errorOUT, bus.end_transactionOUT}, 2'b00);
        end
        reset = 1'b0;
        clear_inputs();

        // ---- round robin: all request, 3-cycle transactions ----
        do_reset();
        bus.request = '1;
        held = 0;
        gap  = 0;
        for (int c = 0; c < 80 && order.size() < 5; c++) begin
            tick();
            if (bus.grant != '0) begin
                if (held == 0) begin
                    order.push_back(onehot_idx(bus.grant));
                    if (order.size() > 1) gaps.push_back(gap);
                end
                held++;
                gap = 0;
            end else begin
                held = 0;
                gap++;
            end
            bus.begin_transactionIN = (held == 1);
            bus.end_transactionIN   = (held == 3);
        end
        clear_inputs();
        check("rr_grant_count", order.size(), 5);
        foreach (order[i]) check($sformatf("rr_order%0d", i), order[i], i % NR);
        // RELEASE then IDLE: two zero-grant cycles between consecutive grants.
        foreach (gaps[i]) check($sformatf("rr_gap%0d", i), gaps[i], 2);

        // ---- begin timeout ----
        do_reset();
        bus.request = 4'b0010;
        run      = 0;
        err_seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (bus.errorOUT || bus.end_transactionOUT) err_seen = 1'b1;
            if (bus.grant == 4'b0010) run++;
            else if (run > 0) break;
        end
        clear_inputs();
        check("bto_grant_cycles", run, BT);
        check("bto_grant_after", bus.grant, '0);
        check("bto_active_after", bus.bus_active, 1'b0);
        check("bto_no_error", err_seen, 1'b0);

        // ---- transaction timeout, no bus end ----
        xfer_timeout_run(0);
        check("xto_active_cycles", act_n, TT);
        check("xto_pulse_count", pulse_n, 1);
        check("xto_pulse_cycle", pulse_cycle, TT);
        check("xto_pulse_pair", pair_ok, 1'b1);
        check("xto_after", {bus.grant, bus.bus_active, bus.errorOUT}, '0);

        // ---- bus end on the edge that would have decided the abort ----
        xfer_timeout_run(TT - 1);
        check("xto_end_active_cycles", act_n, TT - 1);
        check("xto_end_no_pulse", pulse_n, 0);
        check("xto_end_after", {bus.grant, bus.bus_active, bus.errorOUT}, '0);

        // ---- reset mid-transaction with master 2 ----
        do_reset();
        bus.request = 4'b0100;
        tick();
        bus.begin_transactionIN = 1'b1;
        tick();
        bus.begin_transactionIN = 1'b0;
        tick();
        tick();
        check("rmt_active_grant", bus.grant, 4'b0100);
        reset = 1'b1;
        bus.request = 4'b1111;
        tick();
        check("rmt_outputs_zero",
              {bus.grant, bus.bus_active, bus.errorOUT, bus.end_transactionOUT, bus.current_master}, '0);
        reset = 1'b0;
        tick();
        check("rmt_first_grant", bus.grant, 4'b0001);
        check("rmt_first_current", bus.current_master, 2'd0);
        clear_inputs();

        // ---- randomized stimulus against the reference model ----
        do_reset();
        model_reset();
        for (int seg = 0; seg < 6; seg++) begin
            for (int c = 0; c < 600; c++) begin
                logic          r_rst;
                logic [NR-1:0] r_req;
                logic          r_beg;
                logic          r_en;
                logic          r_er;
                r_req = NR'($urandom_range(0, 15));
                case (seg % 3)
                    0: begin // busy traffic with occasional reset
                        r_rst = ($urandom_range(0, 299) == 0);
                        r_beg = ($urandom_range(0, 2) == 0);
                        r_en  = ($urandom_range(0, 5) == 0);
                        r_er  = ($urandom_range(0, 19) == 0);
                    end
                    1: begin // lazy masters: begin timeouts
                        r_rst = 1'b0;
                        r_beg = ($urandom_range(0, 39) == 0);
                        r_en  = ($urandom_range(0, 3) == 0);
                        r_er  = 1'b0;
                    end
                    default: begin // hung transactions: aborts
                        r_rst = 1'b0;
                        r_beg = ($urandom_range(0, 1) == 0);
                        r_en  = ($urandom_range(0, 999) == 0);
                        r_er  = ($urandom_range(0, 999) == 0);
                    end
                endcase
                reset                   = r_rst;
                bus.request             = r_req;
                bus.begin_transactionIN = r_beg;
                bus.end_transactionIN   = r_en;
                bus.errorIN             = r_er;
                model_edge(r_rst, r_req, r_beg, r_en, r_er);
                tick();
                check($sformatf("rand_s%0d_c%0d {grant,act,err,end,cur}", seg, c),
                      {bus.grant, bus.bus_active, bus.errorOUT, bus.end_transactionOUT, bus.current_master},
                      model_outputs());
            end
        end
        reset = 1'b0;
        clear_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
